// File: rtl/multiplier_sequencer_pkg.sv
// Shared types for the M-extension multiplier front end.
// Pure declarations: no logic, no latency.
// Op encoding mirrors the funct3 ordering used by the execute stage.
package mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } mul_seq_state_e;

    // Returns {arg1_signed, arg2_signed}; MUL/MULW only need the low half,
    // which is identical for any signedness, so they use u,u.
    function automatic logic [1:0] op_signedness(input mul_op_e op);
        case (op)
            OP_MULH:   return 2'b11;
            OP_MULHSU: return 2'b10;
            default:   return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/multiplier_sequencer_booth.sv
// Radix-4 Booth multiplier, one digit per clock while start is held.
// Latency: width/2 rounds for the full product, width/4 for the word result.
// No backpressure: operands must stay stable while start=1; start=0 clears it.
module booth_multiplier_multi_cycle #(
    parameter int width = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [width-1:0] arg1,
    input  logic [width-1:0] arg2,
    input  logic             arg1_signed,
    input  logic             arg2_signed,
    output logic [width-1:0] mul,
    output logic [width-1:0] mulh,
    output logic [width-1:0] mulw,
    output logic             mul_busy,
    output logic             mulw_busy
);

    localparam int rounds      = width / 2;
    localparam int word_rounds = width / 4;
    localparam int cw          = $clog2(rounds + 1);
    localparam logic [cw-1:0] last_round = cw'(rounds);
    localparam logic [cw-1:0] word_last  = cw'(word_rounds);

    logic [cw-1:0]      count;
    logic [2*width-1:0] acc;
    logic [width:0]     mplier_x;
    logic [2:0]         digit;
    logic [2*width-1:0] mcand_x;
    logic [2*width-1:0] partial;
    logic [2*width-1:0] correction;
    logic [2*width-1:0] full;

    // arg2 is always recoded as signed; an unsigned arg2 with its MSB set is
    // fixed up at the output by adding arg1 * 2^width.
    assign mplier_x   = {arg2, 1'b0};
    assign mcand_x    = {{width{arg1_signed & arg1[width-1]}}, arg1};
    assign correction = (arg2[width-1] & ~arg2_signed) ? {arg1, {width{1'b0}}} : '0;
    assign full       = acc + correction;
    assign mul        = full[width-1:0];
    assign mulh       = full[2*width-1:width];
    assign mulw       = {{(width/2){acc[width/2-1]}}, acc[width/2-1:0]};
    assign mul_busy   = start & (count != last_round);
    assign mulw_busy  = start & (count < word_last);

    // Select the Booth triple for the current round with constant indices.
    always_comb begin
        digit = 3'b000;
        for (int k = 0; k < rounds; k++) begin
            if (count == cw'(k)) digit = mplier_x[2*k +: 3];
        end
    end

    // Booth digit to partial product (multiple of the sign-extended arg1).
    always_comb begin
        case (digit)
            3'b001, 3'b010: partial = mcand_x;
            3'b011:         partial = mcand_x << 1;
            3'b100:         partial = -(mcand_x << 1);
            3'b101, 3'b110: partial = -mcand_x;
            default:        partial = '0;
        endcase
    end

    // Accumulate one digit per clock; dropping start restarts from zero.
    always_ff @(posedge clock) begin
        if (reset || !start) begin
            count <= '0;
            acc   <= '0;
        end else if (count != last_round) begin
            count <= count + cw'(1);
            acc   <= acc + (partial << {count, 1'b0});
        end
    end

endmodule

// File: rtl/multiplier_sequencer.sv
// Multiply request sequencer with a one-entry product cache.
// Latency: 33 cycles full op, 17 word op, response the cycle after accept on a hit.
// Backpressure: req_ready low from accept until the response handshake or flush.
module multiplier_sequencer
    import mul_pkg::*;
#(
    parameter int width     = 64,
    parameter int tag_width = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic                 req_word,
    input  logic [width-1:0]     req_arg1,
    input  logic [width-1:0]     req_arg2,
    input  logic [tag_width-1:0] req_tag,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [width-1:0]     resp_data,
    output logic [tag_width-1:0] resp_tag
);

    mul_seq_state_e       state;
    logic                 ready_q;
    logic                 start;
    mul_op_e              op_q;
    logic                 word_q;
    logic [width-1:0]     arg1_q;
    logic [width-1:0]     arg2_q;
    logic [1:0]           sgn_q;
    logic [tag_width-1:0] tag_q;

    logic                 c_vld;
    logic [width-1:0]     c_arg1;
    logic [width-1:0]     c_arg2;
    logic [1:0]           c_sgn;
    logic [width-1:0]     c_mul;
    logic [width-1:0]     c_mulh;

    logic [width-1:0]     m_mul, m_mulh, m_mulw;
    logic                 m_mul_busy, m_mulw_busy;

    mul_op_e              req_op_e;
    logic [1:0]           req_sgn;
    logic                 hit;
    logic                 accept;
    logic                 done;

    assign req_op_e  = mul_op_e'(req_op);
    assign req_sgn   = op_signedness(req_op_e);
    assign req_ready = ready_q & ~flush;
    assign accept    = req_valid & req_ready;
    // MUL needs only the low half, which is signedness-independent.
    assign hit       = c_vld & ~req_word & (req_arg1 == c_arg1) & (req_arg2 == c_arg2)
                     & ((req_op_e == OP_MUL) | (req_sgn == c_sgn));
    assign done      = word_q ? ~m_mulw_busy : ~m_mul_busy;

    booth_multiplier_multi_cycle #(.width(width)) u_booth (
        .clock       (clock),
        .reset       (~reset),
        .start       (start),
        .arg1        (arg1_q),
        .arg2        (arg2_q),
        .arg1_signed (sgn_q[1]),
        .arg2_signed (sgn_q[0]),
        .mul         (m_mul),
        .mulh        (m_mulh),
        .mulw        (m_mulw),
        .mul_busy    (m_mul_busy),
        .mulw_busy   (m_mulw_busy)
    );

    // Sequencer FSM: accept, run or serve from cache, respond, flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            ready_q    <= 1'b1;
            start      <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_tag   <= '0;
            op_q       <= OP_MUL;
            word_q     <= 1'b0;
            arg1_q     <= '0;
            arg2_q     <= '0;
            sgn_q      <= 2'b00;
            tag_q      <= '0;
            c_vld      <= 1'b0;
            c_arg1     <= '0;
            c_arg2     <= '0;
            c_sgn      <= 2'b00;
            c_mul      <= '0;
            c_mulh     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= req_op_e;
                        word_q  <= req_word;
                        arg1_q  <= req_arg1;
                        arg2_q  <= req_arg2;
                        sgn_q   <= req_sgn;
                        tag_q   <= req_tag;
                        ready_q <= 1'b0;
                        if (hit) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= (req_op_e == OP_MUL) ? c_mul : c_mulh;
                            resp_tag   <= req_tag;
                        end else begin
                            state <= ST_RUN;
                            start <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state   <= ST_IDLE;
                        start   <= 1'b0;
                        ready_q <= 1'b1;
                    end else if (done) begin
                        state      <= ST_RESP;
                        start      <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_tag   <= tag_q;
                        if (word_q)
                            resp_data <= m_mulw;
                        else
                            resp_data <= (op_q == OP_MUL) ? m_mul : m_mulh;
                        if (!word_q) begin
                            c_vld  <= 1'b1;
                            c_arg1 <= arg1_q;
                            c_arg2 <= arg2_q;
                            c_sgn  <= sgn_q;
                            c_mul  <= m_mul;
                            c_mulh <= m_mulh;
                        end
                    end
                end
                ST_RESP: begin
                    if (flush || resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        ready_q    <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    start   <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // MULW exists only as the word form of MUL.
    a_word_only_mul: assert property (@(posedge clock) disable iff (!reset)
        (req_valid && req_word) |-> (req_op == 2'd0));

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Directed bench for multiplier_sequencer: latency, data, tag, cache, flush,
// backpressure and asynchronous reset behaviour.
module tb_multiplier_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic        req_word = 1'b0;
    logic [63:0] req_arg1 = '0;
    logic [63:0] req_arg2 = '0;
    logic [4:0]  req_tag = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_data;
    logic [4:0]  resp_tag;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] BIG_A = 64'ha0b6b8129b5bdfd9;
    localparam logic [63:0] BIG_B = 64'hbcba1c1981093535;

    logic [127:0] pu, ps, psu;

    multiplier_sequencer #(.width(64), .tag_width(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_word   (req_word),
        .req_arg1   (req_arg1),
        .req_arg2   (req_arg2),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_req_ready"},  64'(req_ready),  64'd1);
        check({name, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({name, "_resp_data"},  resp_data,       64'd0);
        check({name, "_resp_tag"},   64'(resp_tag),   64'd0);
    endtask

    // Present a request and return 1 ns after its accept edge.
    task automatic send(input logic [1:0] op, input logic word, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tag);
        int waited = 0;
        @(negedge clock);
        req_op = op; req_word = word; req_arg1 = a; req_arg2 = b; req_tag = tag;
        req_valid = 1'b1;
        while (!req_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        check("accept", 64'(req_ready), 64'd1);
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    // Count clock edges after the accept edge until resp_valid is seen.
    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic word,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                       input int exp_lat, input logic [63:0] exp_data);
        int lat;
        send(op, word, a, b, tag);
        wait_resp(lat);
        check({name, "_lat"},  64'(lat),      64'(exp_lat));
        check({name, "_data"}, resp_data,     exp_data);
        check({name, "_tag"},  64'(resp_tag), 64'(tag));
    endtask

    task automatic handshake(input string name);
        @(negedge clock);
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
        check({name, "_hs_valid"}, 64'(resp_valid), 64'd0);
        check({name, "_hs_ready"}, 64'(req_ready),  64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;
        pu  = {64'd0, BIG_A} * {64'd0, BIG_B};
        ps  = {{64{BIG_A[63]}}, BIG_A} * {{64{BIG_B[63]}}, BIG_B};
        psu = {{64{BIG_A[63]}}, BIG_A} * {64'd0, BIG_B};

        #12 check_reset_vals("por");
        @(negedge clock) reset = 1'b1;

        // Full op, word op, cache hits and misses by signedness.
        run("mul_big", 2'd0, 1'b0, BIG_A, BIG_B, 5'd5, 33, pu[63:0]);
        handshake("mul_big");
        run("mulw", 2'd0, 1'b1, 64'h00000000ffffffff, 64'd2, 5'd7, 17, 64'hfffffffffffffffe);
        handshake("mulw");
        // Hit: response visible in the cycle following the accept edge.
        run("mulhu_hit", 2'd3, 1'b0, BIG_A, BIG_B, 5'd9, 0, pu[127:64]);
        handshake("mulhu_hit");
        run("mulh_miss", 2'd1, 1'b0, BIG_A, BIG_B, 5'd10, 33, ps[127:64]);
        handshake("mulh_miss");
        run("mulhsu_miss", 2'd2, 1'b0, BIG_A, BIG_B, 5'd11, 33, psu[127:64]);
        handshake("mulhsu_miss");

        // Flush five cycles into a run.
        send(2'd0, 1'b0, 64'd1, 64'd1, 5'd3);
        repeat (4) @(posedge clock);
        @(negedge clock) flush = 1'b1;
        @(posedge clock);
        #1;
        check("flush_valid", 64'(resp_valid), 64'd0);
        check("flush_blocks_ready", 64'(req_ready), 64'd0);
        flush = 1'b0;
        #1 check("flush_idle_ready", 64'(req_ready), 64'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1 if (resp_valid) seen++;
        end
        check("flush_quiet", 64'(seen), 64'd0);
        run("mul_hit_after_flush", 2'd0, 1'b0, BIG_A, BIG_B, 5'd12, 0, pu[63:0]);
        handshake("mul_hit_after_flush");
        run("mul_1x1", 2'd0, 1'b0, 64'd1, 64'd1, 5'd4, 33, 64'd1);
        handshake("mul_1x1");

        // Flush on the completion edge: no response, no cache write.
        send(2'd0, 1'b0, 64'd3, 64'd5, 5'd6);
        repeat (31) @(posedge clock);
        @(negedge clock) flush = 1'b1;
        @(posedge clock);
        #1 check("flush_done_valid", 64'(resp_valid), 64'd0);
        flush = 1'b0;
        run("mul_3x5", 2'd0, 1'b0, 64'd3, 64'd5, 5'd8, 33, 64'd15);
        handshake("mul_3x5");

        // Backpressure: response held stable, no new accept.
        run("mul_bp", 2'd0, 1'b0, 64'd2, 64'd3, 5'd17, 33, 64'd6);
        repeat (10) begin
            @(posedge clock);
            #1;
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_data",  resp_data,       64'd6);
            check("bp_tag",   64'(resp_tag),   64'd17);
            check("bp_ready", 64'(req_ready),  64'd0);
        end
        handshake("mul_bp");

        // Asynchronous reset in the middle of a run.
        send(2'd0, 1'b0, 64'd7, 64'd9, 5'd2);
        repeat (10) @(posedge clock);
        #2 reset = 1'b0;
        #1 check_reset_vals("mid_run_reset");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        run("mul_after_reset", 2'd0, 1'b0, 64'd3, 64'd5, 5'd13, 33, 64'd15);
        handshake("mul_after_reset");
        run("mulh_m1", 2'd1, 1'b0, 64'hffffffffffffffff, 64'hffffffffffffffff, 5'd31, 33, 64'd0);
        handshake("mulh_m1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
